// File: rtl/led_driver_if.sv
// Configuration write bus shared with the other CPU peripherals.
// we: one-cycle write strobe, sel: register select, wdata: write data.
interface led_driver_if;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] wdata;

    modport master (
        output we,
        output sel,
        output wdata
    );

    modport slave (
        input we,
        input sel,
        input wdata
    );
endinterface

// File: rtl/led_driver.sv
// LED output stage: per-bit blinking and global PWM dimming of the LED word.
// Ports: clk, rst (async, active-high), cfg (write bus, slave),
//        led_in[23:0] LED word, led_pad[23:0] registered pads,
//        blink_phase (1 = blinking bits lit).
module led_driver #(
    parameter int unsigned BLINK_HALF = 11_500_000,
    parameter int unsigned PWM_DIV    = 64
) (
    input  logic               clk,
    input  logic               rst,
    led_driver_if.slave        cfg,
    input  logic [23:0]        led_in,
    output logic [23:0]        led_pad,
    output logic               blink_phase
);

    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(PWM_DIV - 1);

    // Configuration state
    logic [23:0]   blink_mask;
    logic [3:0]    brightness;
    logic          blink_en;

    // Timebase state
    logic [PW-1:0] pre_cnt;
    logic [3:0]    pwm_cnt;
    logic [BW-1:0] blink_cnt;

    // Decoded write strobes
    logic wr_mask_lo;
    logic wr_mask_hi;
    logic wr_ctrl;
    logic restart;

    logic pre_wrap;
    logic blink_wrap;
    logic pwm_on;
    logic [23:0] blank;
    logic [23:0] pad_next;

    always_comb begin
        wr_mask_lo = 1'b0;
        wr_mask_hi = 1'b0;
        wr_ctrl    = 1'b0;
        restart    = 1'b0;
        if (cfg.we) begin
            unique case (cfg.sel)
                2'd0: wr_mask_lo = 1'b1;
                2'd1: wr_mask_hi = 1'b1;
                2'd2: wr_ctrl    = 1'b1;
                2'd3: restart    = 1'b1;
                default: ;
            endcase
        end
    end

    assign pre_wrap   = (pre_cnt == PRE_LAST);
    assign blink_wrap = (blink_cnt == BLINK_LAST);

    // Configuration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_mask <= '0;
            brightness <= 4'd15;
            blink_en   <= 1'b0;
        end else begin
            if (wr_mask_lo)
                blink_mask[15:0] <= cfg.wdata;
            if (wr_mask_hi)
                blink_mask[23:16] <= cfg.wdata[7:0];
            if (wr_ctrl) begin
                brightness <= cfg.wdata[3:0];
                blink_en   <= cfg.wdata[4];
            end
        end
    end

    // PWM prescaler and 4-bit PWM counter; restart wins over wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (restart) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            if (pre_wrap)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + PW'(1);
            if (pre_wrap)
                pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    // Blink timebase runs regardless of blink_en so phase stays coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (restart) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_wrap) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BW'(1);
        end
    end

    // Full brightness must be on at pwm_cnt==15 too, hence the special case.
    always_comb begin
        pwm_on = 1'b0;
        if (brightness == 4'd15)
            pwm_on = 1'b1;
        else
            pwm_on = (pwm_cnt < brightness);
    end

    always_comb begin
        blank    = blink_mask & {24{blink_en & ~blink_phase}};
        pad_next = led_in & {24{pwm_on}} & ~blank;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            led_pad <= '0;
        else
            led_pad <= pad_next;
    end

endmodule

// File: doc/led_driver.md
# led_driver

Output stage between the memory-mapped 24-bit LED register and the board LED pins. Consumes the latched LED word and applies per-bit blinking and global PWM dimming, configured through the same 16-bit IO write bus the CPU uses for other peripherals. Output is registered: one clock from input word/configuration to pads.

## Interface
- BLINK_HALF, default 11_500_000: cycles per blink half-period (0.5 s at 23 MHz); legal range ≥2.
- PWM_DIV, default 64: clock cycles per PWM counter step; legal range ≥1.
- clk  in  1  system clock, same domain as the LED register.
- rst  in  1  reset, asynchronous, active-high.
- led_in  in  24  latched LED word from the LED register.
- cfg_we  in  1  configuration write strobe (one cycle per write).
- cfg_sel  in  2  configuration register select.
- cfg_wdata  in  16  configuration write data.
- led_pad  out  24  LED pin drive, registered.
- blink_phase  out  1  current blink phase (1 = blinking bits lit).

## Operation
- Configuration registers, written on the edge where cfg_we=1:
  - sel 0: blink_mask[15:0] <= cfg_wdata[15:0].
  - sel 1: blink_mask[23:16] <= cfg_wdata[7:0]; cfg_wdata[15:8] ignored.
  - sel 2: brightness[3:0] <= cfg_wdata[3:0]; blink_en <= cfg_wdata[4]; other bits ignored.
  - sel 3: phase restart (data ignored): blink_cnt<=0, blink_phase<=1, pre_cnt<=0, pwm_cnt<=0.
- Reset values: blink_mask=0, brightness=15, blink_en=0, blink_cnt=0, blink_phase=1, pre_cnt=0, pwm_cnt=0, led_pad=0.
- Prescaler pre_cnt counts 0..PWM_DIV-1 and wraps; pwm_cnt (4-bit) increments and wraps 15->0 on the cycle pre_cnt wraps. With PWM_DIV=1, pwm_cnt advances every cycle.
- pwm_on = 1 if brightness==15; else (pwm_cnt < brightness). brightness 0 => always off; brightness k (1..14) => k/16 duty.
- Blink counter blink_cnt counts 0..BLINK_HALF-1; on wrap, blink_phase toggles. Counter runs regardless of blink_en.
- Pad function: led_pad <= led_in & {24{pwm_on}} & ~(blink_mask & {24{blink_en & ~blink_phase}}).
- Unmasked bits are never blanked by blinking; blink_en=0 disables all blanking.
- Simultaneous events: sel 3 restart overrides counter wrap/increment in the same cycle; write to sel 2 with a counter wrap both take effect (independent registers).
- Reset mid-operation: all state returns to reset values immediately (asynchronous); led_pad goes 0 without waiting for a clock.

## Timing
- led_pad at edge N+1 is computed from led_in, configuration and counter values sampled at edge N: latency 1 cycle from led_in change.
- Configuration write at edge N updates the register at N; effect visible on led_pad after edge N+1.
- After sel 3 at edge N: blink_phase=1 for exactly BLINK_HALF cycles, toggles on edge N+BLINK_HALF.
- PWM period = 16*PWM_DIV cycles; blink period = 2*BLINK_HALF cycles.
- First led_pad update after reset release is at the first clock edge; no reset synchronizer inside the block.

## Test plan
Bench parameters BLINK_HALF=8, PWM_DIV=1.
- Reset, then led_in=24'hA5A5A5 with no writes -> led_pad=24'hA5A5A5 one cycle later, constant; blink_phase toggles every 8 cycles.
- sel 0 write 16'h00FF, sel 2 write 16'h001F, led_in=24'hFFFFFF -> led_pad alternates FFFFFF (8 cycles) / FFFF00 (8 cycles).
- sel 2 write 16'h0004, led_in=24'h000001 -> led_pad[0] high 4 of every 16 cycles (pwm_cnt 0..3); sel 2 write 16'h0000 -> led_pad=0.
- sel 1 write 16'hFF80 with blink_en=1 -> only bit 23 blinks; cfg_wdata[15:8] has no effect on blink_mask.
- sel 3 write on the same cycle blink_cnt wraps -> no toggle; blink_phase=1, next toggle exactly 8 cycles later.
- Assert rst mid-blink with led_pad nonzero -> led_pad=0 asynchronously; after release brightness=15, blink disabled, led_pad follows led_in.
